// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: shared opcode, accumulator-select, ALU and FSM encodings for the accumulator sequencer
package acc_ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JN   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] SEL_IMM = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [1:0] NC_FETCH = 2'd0;
  localparam logic [1:0] NC_OPRD  = 2'd1;
  localparam logic [1:0] NC_EXEC  = 2'd2;
  localparam logic [1:0] NC_HALT  = 2'd3;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_OPRD   = 3'd3;
  localparam state_t S_EXEC   = 3'd4;
  localparam state_t S_HALT   = 3'd5;
endpackage

// File: rtl/acc_ctrl_decode.sv
// acc_ctrl_decode: combinational opcode classifier (next-state class, alu_op, branch, legality)
// ACC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes route DECODE to HALT instead of back to FETCH
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] nxt_cls,
  output logic [2:0] alu_op,
  output logic       is_branch,
  output logic       is_legal
);
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [1:0] ILL_CLS = NC_HALT;
`else
  localparam logic [1:0] ILL_CLS = NC_FETCH;
`endif
  logic is_alu, is_mem;
  always_comb begin
    is_alu    = opcode >= OP_ADD && opcode <= OP_XOR;
    is_mem    = opcode == OP_LDI || opcode == OP_LDR || opcode == OP_STR;
    is_branch = opcode == OP_JMP || opcode == OP_JZ || opcode == OP_JN;
    is_legal  = !(opcode > OP_JN && opcode < OP_HALT);
    alu_op    = opcode == OP_SUB ? ALU_SUB :
                opcode == OP_AND ? ALU_AND :
                opcode == OP_OR  ? ALU_OR  :
                opcode == OP_XOR ? ALU_XOR : ALU_ADD;
    nxt_cls   = opcode == OP_HALT      ? NC_HALT  :
                is_alu                 ? NC_OPRD  :
                (is_mem || is_branch)  ? NC_EXEC  :
                (opcode == OP_NOP)     ? NC_FETCH : ILL_CLS;
  end
endmodule

// File: rtl/acc_ctrl_seq.sv
// acc_ctrl_seq: multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU
// ACC_CTRL_ILLEGAL_TRAP_EN (resolved in acc_ctrl_decode) makes illegal opcodes halt the core
module acc_ctrl_seq
  import acc_ctrl_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    clb,
  output logic                    instr_req,
  output logic [PC_W-1:0]         instr_addr,
  input  logic                    instr_ack,
  input  logic [7:0]              instr_in,
  input  logic                    acc_zero,
  input  logic                    acc_neg,
  output logic                    load_acc,
  output logic [1:0]              sel_acc,
  output logic [3:0]              immediate,
  output logic [$clog2(NREG)-1:0] reg_addr,
  output logic                    reg_we,
  output logic [2:0]              alu_op,
  output logic                    halted,
  output logic                    illegal
);
  localparam int RW = $clog2(NREG);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      op, immediate_q, immediate_d;
  logic [1:0]      nxt_cls, sel_acc_q, sel_acc_d;
  logic [2:0]      dec_alu, alu_op_q, alu_op_d;
  logic [RW-1:0]   reg_addr_q, reg_addr_d;
  logic            is_branch, is_legal, is_alu, taken, in_op, in_ex;
  logic            instr_req_q, instr_req_d, load_acc_q, load_acc_d, reg_we_q, reg_we_d;
  logic            halted_q, halted_d, illegal_q, illegal_d;

  assign ir_d = (state_q == S_FETCH && instr_ack) ? instr_in : ir_q;
  assign op   = ir_d[7:4];

  acc_ctrl_decode u_decode (
    .opcode    (op),
    .nxt_cls   (nxt_cls),
    .alu_op    (dec_alu),
    .is_branch (is_branch),
    .is_legal  (is_legal)
  );

  assign taken = is_branch && (op == OP_JMP || (op == OP_JZ && acc_zero) || (op == OP_JN && acc_neg));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (instr_ack) begin
        state_d = S_DECODE;
        pc_d    = pc_q + PC_W'(1);
      end
      S_DECODE: begin
        state_d   = nxt_cls == NC_OPRD ? S_OPRD :
                    nxt_cls == NC_EXEC ? S_EXEC :
                    nxt_cls == NC_HALT ? S_HALT : S_FETCH;
        illegal_d = illegal_q | ~is_legal;
      end
      S_OPRD:   state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = taken ? pc_q + {{(PC_W-4){ir_q[3]}}, ir_q[3:0]} : pc_q;
      end
      default:  state_d = S_HALT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    in_op       = state_d == S_DECODE || state_d == S_OPRD || state_d == S_EXEC;
    in_ex       = state_d == S_EXEC;
    is_alu      = nxt_cls == NC_OPRD;
    instr_req_d = state_d == S_FETCH;
    reg_addr_d  = in_op ? ir_d[RW-1:0] : '0;
    alu_op_d    = in_op ? dec_alu : ALU_ADD;
    load_acc_d  = in_ex && (op == OP_LDI || op == OP_LDR || is_alu);
    sel_acc_d   = !in_ex ? SEL_IMM : op == OP_LDR ? SEL_REG : is_alu ? SEL_ALU : SEL_IMM;
    immediate_d = (in_ex && op == OP_LDI) ? ir_d[3:0] : 4'h0;
    reg_we_d    = in_ex && op == OP_STR;
    halted_d    = state_d == S_HALT;
  end

  always_ff @(posedge clk or negedge clb) begin
    if (!clb) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      instr_req_q <= 1'b0;
      load_acc_q  <= 1'b0;
      sel_acc_q   <= SEL_IMM;
      immediate_q <= '0;
      reg_addr_q  <= '0;
      reg_we_q    <= 1'b0;
      alu_op_q    <= ALU_ADD;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instr_req_q <= instr_req_d;
      load_acc_q  <= load_acc_d;
      sel_acc_q   <= sel_acc_d;
      immediate_q <= immediate_d;
      reg_addr_q  <= reg_addr_d;
      reg_we_q    <= reg_we_d;
      alu_op_q    <= alu_op_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_req  = instr_req_q;
  assign instr_addr = pc_q;
  assign load_acc   = load_acc_q;
  assign sel_acc    = sel_acc_q;
  assign immediate  = immediate_q;
  assign reg_addr   = reg_addr_q;
  assign reg_we     = reg_we_q;
  assign alu_op     = alu_op_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
endmodule
